// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings and
// the width-generic evaluation function used by both the datapath and its models.
package logic_pkg;

  localparam int OP_W   = 3;
  localparam int EVAL_W = 64;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ANDN = 3'b100;
  localparam logic [OP_W-1:0] OP_ORN  = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // Evaluated at the widest supported width; callers truncate to their own WIDTH.
  function automatic logic [EVAL_W-1:0] logic_eval(input logic [OP_W-1:0] op,
                                                   input logic [EVAL_W-1:0] a,
                                                   input logic [EVAL_W-1:0] b);
    logic [EVAL_W-1:0] r;
    r = a;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the logic unit.
interface logic_unit_pipe_if
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [WIDTH-1:0]  lhs;
  logic [WIDTH-1:0]  rhs;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_res;
  logic              out_zero;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_op, lhs, rhs, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_op, lhs, rhs, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_tag
  );

endinterface

// File: rtl/pipe_stage.sv
// One register stage of the logic unit: valid bit plus payload, with load
// enable, flush of the valid bit, and synchronous reset of everything.
module pipe_stage #(
  parameter int PW = 38
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          valid,
  output logic [PW-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (load)
        valid <= in_valid;
      // Bubbles and squashed items leave the payload untouched.
      if (load && in_valid && !flush)
        data <= in_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: result and zero flag computed ahead of stage 0,
// then carried with the tag through STAGES backpressured register stages.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  logic_unit_pipe_if.slave   bus
);

  localparam int PW = WIDTH + 1 + TAG_W;

  logic [WIDTH-1:0]  res_p0;
  logic              zero_p0;
  logic [PW-1:0]     pay_p0;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] ld;
  logic [PW-1:0]     pay [STAGES];

  assign res_p0  = WIDTH'(logic_eval(bus.in_op, EVAL_W'(bus.lhs), EVAL_W'(bus.rhs)));
  assign zero_p0 = (res_p0 == '0);
  assign pay_p0  = {res_p0, zero_p0, bus.in_tag};

  // Ready ripples back from the output; a stage can move when the next one
  // is empty or itself moving.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = bus.out_ready;
    for (int i = STAGES - 2; i >= 0; i--)
      rdy[i] = !vld[i+1] || rdy[i+1];
  end

  assign ld = ~vld | rdy;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          v_in;
    logic [PW-1:0] d_in;

    if (g == 0) begin : g_first
      assign v_in = bus.in_valid;
      assign d_in = pay_p0;
    end else begin : g_rest
      assign v_in = vld[g-1];
      assign d_in = pay[g-1];
    end

    pipe_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (ld[g]),
      .in_valid (v_in),
      .in_data  (d_in),
      .valid    (vld[g]),
      .data     (pay[g])
    );
  end

  // Output boundary: driven straight from the last stage registers.
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[STAGES-1];
  assign {bus.out_res, bus.out_zero, bus.out_tag} = pay[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed checks on a 32-bit, 2-stage unit plus scoreboarded random traffic
// on the 8-bit/1-stage and 64-bit/4-stage corners.
module tb_logic_unit_pipe;
  import logic_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic [4:0]  tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic        rv;
  logic [2:0]  rop;
  logic [63:0] rl;
  logic [63:0] rr;
  logic [4:0]  rtag;
  logic        rrdy;

  sb_t qb[$];
  sb_t qc[$];

  logic [31:0] exp_sweep [8];

  logic_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) ifa ();
  logic_unit_pipe_if #(.WIDTH(8),  .TAG_W(5)) ifb ();
  logic_unit_pipe_if #(.WIDTH(64), .TAG_W(5)) ifc ();

  logic_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifa));
  logic_unit_pipe #(.WIDTH(8),  .STAGES(1), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifb));
  logic_unit_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(5)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc));

  assign ifb.in_valid  = rv;
  assign ifb.in_op     = rop;
  assign ifb.lhs       = rl[7:0];
  assign ifb.rhs       = rr[7:0];
  assign ifb.in_tag    = rtag;
  assign ifb.out_ready = rrdy;
  assign ifc.in_valid  = rv;
  assign ifc.in_op     = rop;
  assign ifc.lhs       = rl;
  assign ifc.rhs       = rr;
  assign ifc.in_tag    = rtag;
  assign ifc.out_ready = rrdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_cycle();
    sb_t e;
    logic [63:0] ev;
    if (ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) check("b_spurious_out", {63'd0, ifb.out_valid}, 64'd0);
      else begin
        e = qb.pop_front();
        check("b_res",  {56'd0, ifb.out_res}, e.res);
        check("b_zero", {63'd0, ifb.out_zero}, {63'd0, e.zero});
        check("b_tag",  {59'd0, ifb.out_tag}, {59'd0, e.tag});
      end
    end
    if (ifc.out_valid && ifc.out_ready) begin
      if (qc.size() == 0) check("c_spurious_out", {63'd0, ifc.out_valid}, 64'd0);
      else begin
        e = qc.pop_front();
        check("c_res",  ifc.out_res, e.res);
        check("c_zero", {63'd0, ifc.out_zero}, {63'd0, e.zero});
        check("c_tag",  {59'd0, ifc.out_tag}, {59'd0, e.tag});
      end
    end
    if (ifb.in_valid && ifb.in_ready) begin
      ev = logic_eval(rop, {56'd0, rl[7:0]}, {56'd0, rr[7:0]}) & 64'hFF;
      e.res = ev; e.zero = (ev == 64'd0); e.tag = rtag;
      qb.push_back(e);
    end
    if (ifc.in_valid && ifc.in_ready) begin
      ev = logic_eval(rop, rl, rr);
      e.res = ev; e.zero = (ev == 64'd0); e.tag = rtag;
      qc.push_back(e);
    end
  endtask

  initial begin
    int lat_b;
    int lat_c;
    n_cmp = 0; n_bad = 0;
    exp_sweep[0] = 32'h00F0_1234; exp_sweep[1] = 32'hFFF0_FFFF;
    exp_sweep[2] = 32'hFF00_EDCB; exp_sweep[3] = 32'h000F_0000;
    exp_sweep[4] = 32'hF000_0000; exp_sweep[5] = 32'hF0FF_1234;
    exp_sweep[6] = 32'h00FF_1234; exp_sweep[7] = 32'hF0F0_1234;
    rv = 0; rop = 0; rl = 0; rr = 0; rtag = 0; rrdy = 0;

    // Reset with a live input
    rst = 1; flush = 0;
    ifa.in_valid = 1; ifa.in_op = OP_PASS; ifa.lhs = 32'hDEAD_BEEF;
    ifa.rhs = 32'h0; ifa.in_tag = 5'd9; ifa.out_ready = 1;
    tick(); tick();
    check("rst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
    check("rst_out_res",   {32'd0, ifa.out_res}, 64'd0);
    check("rst_out_zero",  {63'd0, ifa.out_zero}, 64'd0);
    check("rst_out_tag",   {59'd0, ifa.out_tag}, 64'd0);
    rst = 0; ifa.in_valid = 0;
    #1;
    check("rst_in_ready", {63'd0, ifa.in_ready}, 64'd1);

    // Op sweep, back to back
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        ifa.in_valid = 1; ifa.in_op = 3'(t);
        ifa.lhs = 32'hF0F0_1234; ifa.rhs = 32'h0FF0_FFFF; ifa.in_tag = 5'(t + 1);
      end else ifa.in_valid = 0;
      tick();
      if (t >= 1 && t <= 8) begin
        check($sformatf("sweep_vld%0d", t - 1), {63'd0, ifa.out_valid}, 64'd1);
        check($sformatf("sweep_res%0d", t - 1), {32'd0, ifa.out_res}, {32'd0, exp_sweep[t-1]});
        check($sformatf("sweep_tag%0d", t - 1), {59'd0, ifa.out_tag}, 64'(t));
        check($sformatf("sweep_zero%0d", t - 1), {63'd0, ifa.out_zero}, 64'd0);
      end else if (t == 9) begin
        check("sweep_end_vld", {63'd0, ifa.out_valid}, 64'd0);
      end
    end

    // Zero flag
    ifa.in_valid = 1; ifa.in_op = OP_AND; ifa.lhs = 32'hAAAA_AAAA; ifa.rhs = 32'h5555_5555; ifa.in_tag = 5'd3;
    tick();
    ifa.in_op = OP_PASS; ifa.lhs = 32'h1; ifa.in_tag = 5'd4;
    tick();
    ifa.in_valid = 0;
    check("zero_res",  {32'd0, ifa.out_res}, 64'd0);
    check("zero_flag", {63'd0, ifa.out_zero}, 64'd1);
    check("zero_tag",  {59'd0, ifa.out_tag}, 64'd3);
    tick();
    check("nz_res",  {32'd0, ifa.out_res}, 64'd1);
    check("nz_flag", {63'd0, ifa.out_zero}, 64'd0);
    tick();
    check("zero_end_vld", {63'd0, ifa.out_valid}, 64'd0);

    // Backpressure: only STAGES items fit
    ifa.out_ready = 0; ifa.in_op = OP_PASS; ifa.rhs = 32'h0;
    ifa.in_valid = 1; ifa.lhs = 32'd10; ifa.in_tag = 5'd10;
    #1; check("bp_rdy0", {63'd0, ifa.in_ready}, 64'd1);
    tick();
    ifa.lhs = 32'd11; ifa.in_tag = 5'd11;
    #1; check("bp_rdy1", {63'd0, ifa.in_ready}, 64'd1);
    tick();
    ifa.lhs = 32'd12; ifa.in_tag = 5'd12;
    #1; check("bp_full", {63'd0, ifa.in_ready}, 64'd0);
    tick();
    check("bp_hold_vld", {63'd0, ifa.out_valid}, 64'd1);
    check("bp_hold_tag", {59'd0, ifa.out_tag}, 64'd10);
    tick();
    check("bp_hold_res", {32'd0, ifa.out_res}, 64'd10);
    check("bp_hold_tag2", {59'd0, ifa.out_tag}, 64'd10);
    ifa.out_ready = 1;
    #1; check("bp_pop_push_rdy", {63'd0, ifa.in_ready}, 64'd1);
    tick();
    ifa.in_valid = 0;
    check("bp_out11", {59'd0, ifa.out_tag}, 64'd11);
    tick();
    check("bp_out12_vld", {63'd0, ifa.out_valid}, 64'd1);
    check("bp_out12", {59'd0, ifa.out_tag}, 64'd12);
    tick();
    check("bp_end_vld", {63'd0, ifa.out_valid}, 64'd0);

    // Flush during stall with a live input
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.lhs = 32'd20; ifa.in_tag = 5'd20;
    tick();
    ifa.lhs = 32'd21; ifa.in_tag = 5'd21;
    tick();
    ifa.lhs = 32'd22; ifa.in_tag = 5'd22; flush = 1;
    #1; check("fl_in_ready", {63'd0, ifa.in_ready}, 64'd0);
    tick();
    flush = 0; ifa.in_valid = 0;
    #1;
    check("fl_out_vld", {63'd0, ifa.out_valid}, 64'd0);
    check("fl_in_ready_after", {63'd0, ifa.in_ready}, 64'd1);
    ifa.out_ready = 1; ifa.in_valid = 1; ifa.lhs = 32'd23; ifa.in_tag = 5'd23;
    tick();
    ifa.in_valid = 0;
    check("fl_lat1_vld", {63'd0, ifa.out_valid}, 64'd0);
    tick();
    check("fl_next_vld", {63'd0, ifa.out_valid}, 64'd1);
    check("fl_next_tag", {59'd0, ifa.out_tag}, 64'd23);
    check("fl_next_res", {32'd0, ifa.out_res}, 64'd23);
    tick();
    check("fl_end_vld", {63'd0, ifa.out_valid}, 64'd0);

    // Reset mid-operation clears held data too
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.lhs = 32'hFFFF_FFFF; ifa.in_tag = 5'd7;
    tick();
    ifa.in_valid = 0;
    tick();
    check("mr_held_tag", {59'd0, ifa.out_tag}, 64'd7);
    rst = 1;
    tick();
    rst = 0;
    check("mr_vld", {63'd0, ifa.out_valid}, 64'd0);
    check("mr_res", {32'd0, ifa.out_res}, 64'd0);
    check("mr_tag", {59'd0, ifa.out_tag}, 64'd0);

    // Random traffic on the parameter corners
    for (int c = 0; c < 400; c++) begin
      rv   = 1'($urandom_range(0, 1));
      rop  = 3'($urandom_range(0, 7));
      rl   = {$urandom, $urandom};
      rr   = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rl = rr;
      rtag = 5'($urandom);
      rrdy = ($urandom_range(0, 3) != 0);
      #1;
      sb_cycle();
      tick();
    end
    rv = 0; rrdy = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      sb_cycle();
      tick();
    end
    check("b_drain", 64'(qb.size()), 64'd0);
    check("c_drain", 64'(qc.size()), 64'd0);

    // Latency of a lone item with no backpressure
    rv = 1; rop = OP_PASS; rl = 64'h5A; rtag = 5'd1; rrdy = 1;
    lat_b = 0; lat_c = 0;
    tick();
    rv = 0;
    for (int k = 1; k <= 10; k++) begin
      if (ifb.out_valid && lat_b == 0) lat_b = k;
      if (ifc.out_valid && lat_c == 0) lat_c = k;
      tick();
    end
    check("b_latency", 64'(lat_b), 64'd1);
    check("c_latency", 64'(lat_c), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the execute stage. Generalises the single-function 32-bit AND to eight logic operations, configurable width and depth, a result tag, and a zero flag.
- Uses a valid/ready handshake with full backpressure and a flush input for branch mispredict and trap squash.
- Sits between the issue logic and the writeback arbiter.

Parameters:
- WIDTH, 32: operand and result width in bits; 8..64.
- STAGES, 2: number of register stages, which is also the latency; 1..4.
- TAG_W, 5: width of the destination-register tag carried alongside the data.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squashes every in-flight item.
- in_valid  in  1  input item present.
- in_ready  out  1  unit accepts the input item this cycle.
- in_op  in  3  operation select; encodings in the package.
- lhs  in  WIDTH  operand A.
- rhs  in  WIDTH  operand B.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result present at the last stage.
- out_ready  in  1  downstream accepts the result.
- out_res  out  WIDTH  result.
- out_zero  out  1  set when out_res == 0.
- out_tag  out  TAG_W  tag travelling with the result.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. While rst=1 at an edge, every stage valid, data, tag and zero register is cleared to 0. After reset: out_valid=0, out_res=0, out_zero=0, out_tag=0. rst has priority over flush and over any handshake.
- Op encodings (from the package):
  - 000 AND: lhs&rhs
  - 001 OR: lhs|rhs
  - 010 XOR: lhs^rhs
  - 011 NOR: ~(lhs|rhs)
  - 100 ANDN: lhs&~rhs
  - 101 ORN: lhs|~rhs
  - 110 XNOR: ~(lhs^rhs)
  - 111 PASS: lhs
- Arithmetic and width rules: all ops are purely bitwise at WIDTH bits, with no carries and no extension.
- Where compute happens: the result and zero flag are computed combinationally from the input and captured in stage 0. Stages 1..STAGES-1 are plain registers. out_* are driven directly by the stage STAGES-1 registers.
- Stage advance:
  - ready_last = out_ready.
  - ready_i = !valid_{i+1} || ready_{i+1}.
  - Stage i loads from its predecessor (stage 0 loads from the input) when !valid_i || ready_i.
  - On a load, valid_i takes the predecessor's valid. Data, tag and zero registers update only when the incoming item is valid; a bubble leaves them unchanged.
- in_ready = !valid_0 || ready_0. This is a combinational path through the chain; no skid buffer.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - A held output (out_valid=1, out_ready=0) keeps out_res, out_zero and out_tag stable until it is accepted.
- Throughput and latency: with out_ready held high, one result per cycle. An item accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. latency STAGES cycles.
- Full pipeline: with out_ready=0, the unit absorbs exactly STAGES items, then in_ready=0. Raising out_ready makes in_ready=1 in that same cycle, giving simultaneous pop and push.
- Flush: when flush=1 at an edge, all valid bits go to 0, an item presented in that cycle is dropped, and data registers are left unchanged. in_ready keeps its normal value during the flush cycle. out_valid is 0 in the cycle after a flush.
- Flush during stall: a held output is discarded even though out_ready=0.
- Reset mid-operation: behaves as flush, and in addition clears the data registers.

Decomposition:
- Package logic_pkg: op encoding localparams OP_AND..OP_PASS, the op width constant (3), and a function logic_eval(op, a, b) used by the RTL and by the bench model.
- Sub-module pipe_stage (WIDTH+TAG_W+1 payload, valid, load enable, flush, reset), instantiated STAGES times via generate.

Test Plan:
- Reset: hold rst=1 with in_valid=1 -> out_valid=0, out_res=0, out_zero=0, out_tag=0; once rst=0, in_ready=1.
- Op sweep, STAGES=2, WIDTH=32, out_ready=1, lhs=32'hF0F0_1234, rhs=32'h0FF0_FFFF, ops 0..7 back to back -> results 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, 0xF000_0000, 0xF0FF_1234, 0x00FF_1234, 0xF0F0_1234 on consecutive cycles starting 2 cycles after the first accept; tags in order.
- Zero flag: AND of 0xAAAA_AAAA and 0x5555_5555 -> out_res=0, out_zero=1. PASS of 1 -> out_zero=0.
- Backpressure: out_ready=0, push 3 items -> only 2 accepted, in_ready=0. Raise out_ready -> items pop in order with no loss and no duplication, and a new push is accepted in the same cycle.
- Flush: 2 items in flight with out_ready=0, assert flush for 1 cycle with in_valid=1 -> out_valid=0 next cycle, no flushed tag ever appears, and the next pushed item emerges after STAGES cycles.
- Parameter corners: STAGES=1 with WIDTH=8, and STAGES=4 with WIDTH=64 -> random stimulus with random out_ready matches the logic_eval scoreboard; latency equals STAGES.
